// File: rtl/cc_irq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cc_irq_pkg
// Brief    : Shared encodings for the event IRQ scheduler (states, register map).
// Revision : 1.0 - initial release
// ============================================================================
package cc_irq_pkg;

  localparam int MAX_SRC = 8;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ASSERT  = 2'd1;
  localparam logic [1:0] HOLDOFF = 2'd2;

  localparam logic [2:0] PEND = 3'd0;
  localparam logic [2:0] MASK = 3'd1;
  localparam logic [2:0] VECT = 3'd2;
  localparam logic [2:0] CLR  = 3'd3;
  localparam logic [2:0] STAT = 3'd4;

  // An invalid vector reads as all zeros so a stale grant ID never leaks out.
  function automatic logic [31:0] vector_word(input logic valid, input logic [2:0] id);
    return valid ? {1'b1, 28'd0, id} : 32'd0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/irq_priority_picker.sv
`default_nettype none
// ============================================================================
// Module   : irq_priority_picker
// Brief    : Combinational picker; first set request at or after 'start', wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module irq_priority_picker
  import cc_irq_pkg::*;
#(
  parameter int NUM_SRC = 4
)(
  input  logic [NUM_SRC-1:0] req,
  input  logic [2:0]         start,
  output logic [2:0]         grant_id,
  output logic               grant_valid
);

  logic [MAX_SRC-1:0] w_req;
  logic [3:0]         w_idx;

  assign w_req = MAX_SRC'(req);

  // Walk from the far end back towards 'start' so the closest hit is written last.
  always_comb begin
    grant_id    = 3'd0;
    grant_valid = 1'b0;
    w_idx       = 4'd0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      w_idx = {1'b0, start} + 4'(k);
      if (w_idx >= 4'(NUM_SRC))
        w_idx = w_idx - 4'(NUM_SRC);
      if (w_req[w_idx[2:0]]) begin
        grant_id    = w_idx[2:0];
        grant_valid = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/event_irq_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : event_irq_scheduler
// Brief    : AHB-lite slave latching event edges and serving them on one IRQ.
//            IRQ_ROUND_ROBIN_EN selects round-robin instead of fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
module event_irq_scheduler
  import cc_irq_pkg::*;
#(
  parameter int NUM_SRC     = 4,
  parameter int IRQ_HOLDOFF = 2
)(
  input  logic               HCLK,
  input  logic               HRESETn,
  input  logic [31:0]        HADDR,
  input  logic [31:0]        HWDATA,
  input  logic               HWRITE,
  input  logic               HREADY,
  input  logic               HSEL,
  input  logic [2:0]         HSIZE,
  input  logic [1:0]         HTRANS,
  input  logic [NUM_SRC-1:0] EVT,
  output logic [31:0]        HRDATA,
  output logic               HREADYOUT,
  output logic               IRQ
);

  localparam logic [3:0]         c_hold_load = 4'(IRQ_HOLDOFF - 1);
  localparam logic [NUM_SRC-1:0] c_one       = NUM_SRC'(1);

  logic               r_active, r_write;
  logic [2:0]         r_addr;
  logic [NUM_SRC-1:0] r_evt_last, r_pend, r_mask, r_ovf;
  logic [1:0]         r_state;
  logic [2:0]         r_grant;
  logic [3:0]         r_hold_cnt;
  logic               r_irq;

  logic               w_addr_phase, w_rd, w_wr, w_ack, w_grant_live;
  logic [NUM_SRC-1:0] w_edge, w_clr_bits, w_ack_bits, w_grant_bit;
  logic [2:0]         w_start, w_pick_id;
  logic               w_pick_valid;
  logic [31:0]        w_rdata;
  logic               w_unused;

  assign w_addr_phase = HSEL && HREADY && (HTRANS != 2'b00);
  assign w_rd         = r_active && !r_write;
  assign w_wr         = r_active && r_write;
  assign w_ack        = w_rd && (r_addr == VECT) && (r_state == ASSERT);
  assign w_edge       = EVT & ~r_evt_last;
  assign w_clr_bits   = (w_wr && (r_addr == CLR)) ? HWDATA[NUM_SRC-1:0] : '0;
  assign w_grant_bit  = c_one << r_grant;
  assign w_ack_bits   = w_ack ? w_grant_bit : '0;
  assign w_grant_live = |(w_grant_bit & r_pend & r_mask);
  assign w_unused     = ^{HADDR[31:5], HADDR[1:0], HSIZE, HWDATA};

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_active <= 1'b0;
      r_write  <= 1'b0;
      r_addr   <= 3'd0;
    end else begin
      r_active <= w_addr_phase;
      if (w_addr_phase) begin
        r_write <= HWRITE;
        r_addr  <= HADDR[4:2];
      end
    end
  end

  // New edges are OR-ed in after clears so a coincident event is never lost.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_evt_last <= '0;
      r_pend     <= '0;
      r_mask     <= '0;
      r_ovf      <= '0;
    end else begin
      r_evt_last <= EVT;
      r_pend     <= (r_pend & ~w_clr_bits & ~w_ack_bits) | w_edge;
      r_ovf      <= ((w_wr && (r_addr == STAT)) ? '0 : r_ovf) | (w_edge & r_pend);
      if (w_wr && (r_addr == MASK))
        r_mask <= HWDATA[NUM_SRC-1:0];
    end
  end

`ifdef IRQ_ROUND_ROBIN_EN
  logic [2:0] r_rr_ptr;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)
      r_rr_ptr <= 3'd0;
    else if (w_ack)
      r_rr_ptr <= r_grant;
  end

  assign w_start = (r_rr_ptr == 3'(NUM_SRC - 1)) ? 3'd0 : r_rr_ptr + 3'd1;
`else
  assign w_start = 3'd0;
`endif

  irq_priority_picker #(.NUM_SRC(NUM_SRC)) u_picker (
    .req         (r_pend & r_mask),
    .start       (w_start),
    .grant_id    (w_pick_id),
    .grant_valid (w_pick_valid)
  );

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state    <= IDLE;
      r_grant    <= 3'd0;
      r_hold_cnt <= 4'd0;
      r_irq      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pick_valid) begin
            r_grant <= w_pick_id;
            r_irq   <= 1'b1;
            r_state <= ASSERT;
          end
        end
        ASSERT: begin
          // Software masking or clearing the granted source withdraws the request.
          if (w_ack || !w_grant_live) begin
            r_irq      <= 1'b0;
            r_hold_cnt <= c_hold_load;
            r_state    <= HOLDOFF;
          end
        end
        HOLDOFF: begin
          if (r_hold_cnt == 4'd0)
            r_state <= IDLE;
          else
            r_hold_cnt <= r_hold_cnt - 4'd1;
        end
        default: begin
          r_irq   <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    w_rdata = 32'd0;
    case (r_addr)
      PEND:    w_rdata = 32'(r_pend);
      MASK:    w_rdata = 32'(r_mask);
      VECT:    w_rdata = vector_word(r_state == ASSERT, r_grant);
      STAT:    w_rdata = {16'd0, 8'(r_ovf), 6'd0, r_state};
      default: w_rdata = 32'd0;
    endcase
  end

  assign HRDATA    = w_rd ? w_rdata : 32'd0;
  assign HREADYOUT = 1'b1;
  assign IRQ       = r_irq;

endmodule
`default_nettype wire
